// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
package pipeline_hazard_ctrl_pkg;

  localparam int WORD_SIZE        = 16;
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: the ID instruction reads the register a load in EX writes.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [1:0] ex_rd,
  input  logic [1:0] id_rs,
  input  logic [1:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       load_use
);

  always_comb begin
    load_use = 1'b0;
    if (ex_mem_read) begin
      load_use = (id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd));
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: per-cycle enables, HLT drain FSM and saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       id_rs,
  input  logic [1:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [1:0]       ex_rd,
  input  logic             ex_mispredict,
  input  logic             id_jump,
  input  logic             id_halt,
  input  logic             i_mem_ready,
  input  logic             d_mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

  hz_state_e        state_q, state_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             freeze_s;
  logic             load_use_s;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .load_use    (load_use_s)
  );

  assign freeze_s    = !i_mem_ready || !d_mem_ready;
  assign stall_count = stall_count_q;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = RUN;
      drain_cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (freeze_s) begin
            pipe_freeze = 1'b1;
          end else if (ex_mispredict) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use_s) begin
            id_ex_flush = 1'b1;
          end else if (id_jump) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else if (id_halt) begin
            id_ex_flush = 1'b1;
            // A single-bubble drain finishes in the HLT cycle itself.
            state_d     = (DRAIN_CYCLES > 1) ? DRAIN : HALTED;
            drain_cnt_d = DCW'(DRAIN_CYCLES - 1);
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        DRAIN: begin
          if (freeze_s) begin
            pipe_freeze = 1'b1;
          end else if (ex_mispredict) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = RUN;
            drain_cnt_d = '0;
          end else begin
            id_ex_flush = 1'b1;
            if (drain_cnt_q <= DCW'(1)) begin
              state_d     = HALTED;
              drain_cnt_d = '0;
            end else begin
              drain_cnt_d = drain_cnt_q - DCW'(1);
            end
          end
        end
        HALTED: begin
          halted      = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: begin
          id_ex_flush = 1'b1;
          state_d     = RUN;
          drain_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (reset) begin
      stall_count_d = '0;
    end else if ((state_q != HALTED) && !pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      drain_cnt_q   <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 16-bit, four-register pipelined CPU. Each cycle it decides whether the PC and IF/ID advance and whether IF/ID and ID/EX are flushed to bubbles. It drives the `flush_signal` input of ID/EX. It also sequences a clean halt drain and counts stall cycles for the testbench.

## Interface
- `DRAIN_CYCLES`, default 3: bubbles inserted after HLT is seen in ID before `halted` rises (EX, MEM, WB).
- `CNT_W`, default 16: width of `stall_count`.

- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-high reset.
- `id_rs`, `id_rt`, in, 2 each: source register indices of the instruction in ID.
- `id_use_rs`, `id_use_rt`, in, 1 each: the ID instruction actually reads that source.
- `ex_mem_read`, in, 1: the instruction in EX is a load.
- `ex_rd`, in, 2: destination register of the instruction in EX.
- `ex_mispredict`, in, 1: a branch or JPR/JRL resolved in EX disagrees with the fetched path.
- `id_jump`, in, 1: JMP/JAL is decoded in ID. Its target is taken in ID.
- `id_halt`, in, 1: HLT is decoded in ID.
- `i_mem_ready`, `d_mem_ready`, in, 1 each: the memory ports complete this cycle.
- `pc_write`, out, 1: PC register loads its next value.
- `if_id_write`, out, 1: IF/ID captures.
- `if_id_flush`, out, 1: IF/ID is loaded with a bubble.
- `id_ex_flush`, out, 1: ID/EX control bits are zeroed (bubble).
- `pipe_freeze`, out, 1: ID/EX, EX/MEM and MEM/WB hold their contents.
- `halted`, out, 1: the drain is complete and the pipeline is idle.
- `stall_count`, out, `CNT_W`: number of cycles with `pc_write`=0 outside reset and HALTED.

## Operation
- States:
  - RUN: normal operation.
  - DRAIN: HLT is draining; `drain_cnt` holds the bubbles remaining.
  - HALTED: pipeline is idle.
- Outputs are combinational from state and inputs. State, `drain_cnt` and `stall_count` update on the rising edge of `clk`.
- Signals used below:
  - `freeze` = !`i_mem_ready` || !`d_mem_ready`.
  - `load_use` = `ex_mem_read` && ((`id_use_rs` && `id_rs`==`ex_rd`) || (`id_use_rt` && `id_rt`==`ex_rd`)).
- Priority in RUN, highest first:
  1. `freeze`: `pipe_freeze`=1; `pc_write`, `if_id_write`, both flushes = 0. This masks every lower event; a pending mispredict is acted on after the freeze ends.
  2. `ex_mispredict`: `pc_write`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_flush`=1.
  3. `load_use`: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. One bubble; forwarding covers the rest.
  4. `id_jump`: `pc_write`=1, `if_id_write`=1, `if_id_flush`=1.
  5. `id_halt`: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. Go to DRAIN with `drain_cnt`=`DRAIN_CYCLES`-1.
  6. Otherwise: `pc_write`=1, `if_id_write`=1, flushes=0.
- DRAIN:
  - `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1.
  - `freeze` holds `drain_cnt` unchanged.
  - `ex_mispredict` (the HLT was wrong-path) aborts the drain: apply rule 2 and return to RUN.
  - Otherwise decrement `drain_cnt`; at 0, go to HALTED.
- HALTED: `halted`=1, `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. Only `reset` exits this state.
- `stall_count` increments by 1 each cycle `pc_write`=0 in RUN or DRAIN. It saturates at all-ones.

## Timing
- During the reset cycle: `pc_write`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_flush`=1, `pipe_freeze`=0, `halted`=0.
- After the reset edge: state=RUN, `drain_cnt`=0, `stall_count`=0.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge.
- Zero-cycle latency: flush and write enables act on the same rising edge at which the hazard is presented.
- Load-use stall is exactly 1 cycle. On the next cycle the load sits in MEM, so `load_use` is 0.
- Mispredict and `load_use` in the same cycle: only the mispredict is acted on; no stall.
- `freeze` together with `id_halt`: no state change until `freeze` drops.
- HLT presented in cycle N with no other events: `halted` rises in cycle N+`DRAIN_CYCLES`.

## Structure
- Shared package/header (alongside `WORD_SIZE`): state encodings RUN=2'd0, DRAIN=2'd1, HALTED=2'd2, and the `DRAIN_CYCLES` default.
- One sub-module, `hazard_detect`: purely combinational `load_use` compare, reused by the forwarding checker.
- The top level holds the FSM, drain counter and saturating stall counter.

## Test plan
- Load-use: LWD into r1 in EX, ADD reading r1 in ID → one cycle with `pc_write`=0 and `id_ex_flush`=1; `stall_count`=1.
- Mispredict and `load_use` together → `if_id_flush`=`id_ex_flush`=1, `pc_write`=1; `stall_count` unchanged.
- `d_mem_ready` low for 4 cycles while `ex_mispredict`=1 → `pipe_freeze`=1 for 4 cycles with no flushes; the flush follows on cycle 5; `stall_count`=4.
- HLT in ID at cycle 10 → `halted`=1 from cycle 13; `stall_count` increments by 3.
- HLT enters DRAIN, then `ex_mispredict` in the first DRAIN cycle → both flushes asserted, back to RUN, `halted` stays 0.
- Force `stall_count` to 16'hFFFE and stall 3 cycles → it holds 16'hFFFF. Then `reset` mid-DRAIN → state RUN, counter 0.
